// File: rtl/md5_pkg.sv
// Shared constants and FSM state encoding for the MD5 byte packer.
package md5_pkg;

  localparam int unsigned BLOCK_BITS = 512;
  localparam int unsigned LEN_BITS   = 64;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    HOLD,
    FINAL,
    WAIT_FIN,
    DRAIN
  } state_t;

endpackage

// File: rtl/md5_hold_timer.sv
// Loadable down-counter; zero is high whenever the count has run out.
module md5_hold_timer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/md5_packer.sv
// Packs a byte stream into 512-bit blocks for md5_ctrl, tracking the
// committed bit length and sequencing start/finish/done around each message.
module md5_packer
  import md5_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES  = 96,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic                  in_clk,
  input  logic                  reset,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  input  logic                  byte_last,
  output logic                  byte_ready,
  output logic [BLOCK_BITS-1:0] indata,
  output logic [LEN_BITS-1:0]   len,
  output logic                  start,
  input  logic                  finish,
  output logic                  done
);

  localparam int unsigned TMR_W = 32;

  state_t                state_q, state_d;
  logic [5:0]            k_q, k_d;
  logic [LEN_BITS-1:0]   total_q, total_d;
  logic [LEN_BITS-1:0]   len_q, len_d;
  logic [BLOCK_BITS-1:0] buf_q, buf_d, buf_wr;
  logic [BLOCK_BITS-1:0] indata_q, indata_d;
  logic                  start_q, start_d;
  logic                  done_q, done_d;
  logic                  pend_q, pend_d;
  logic                  ready_q, ready_d;
  logic                  accept;
  logic                  tmr_load, tmr_zero;
  logic [TMR_W-1:0]      tmr_val;

  md5_hold_timer #(
    .WIDTH(TMR_W)
  ) u_timer (
    .clk     (in_clk),
    .reset   (reset),
    .load    (tmr_load),
    .load_val(tmr_val),
    .zero    (tmr_zero)
  );

  assign accept = byte_valid && ready_q;

  always_comb begin
    buf_wr = buf_q;
    buf_wr[{k_q, 3'b000} +: 8] = byte_data;
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    total_d  = total_q;
    buf_d    = buf_q;
    indata_d = indata_q;
    len_d    = len_q;
    start_d  = 1'b0;
    done_d   = 1'b0;
    pend_d   = pend_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      IDLE, FILL: begin
        if (accept) begin
          buf_d   = buf_wr;
          k_d     = k_q + 6'd1;
          total_d = total_q + 64'd8;
          state_d = FILL;
          // A last byte landing in slot 63 still commits as a plain full
          // block; the empty final block follows once HOLD expires.
          if (k_q == 6'd63) begin
            indata_d = buf_wr;
            len_d    = len_q + 64'd512;
            buf_d    = '0;
            k_d      = '0;
            pend_d   = byte_last;
            state_d  = HOLD;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(HOLD_CYCLES - 1);
          end else if (byte_last) begin
            indata_d = buf_wr;
            len_d    = total_q + 64'd8;
            buf_d    = '0;
            k_d      = '0;
            start_d  = 1'b1;
            state_d  = WAIT_FIN;
          end
        end
      end
      HOLD: begin
        if (tmr_zero) begin
          state_d = pend_q ? FINAL : FILL;
          pend_d  = 1'b0;
        end
      end
      FINAL: begin
        indata_d = '0;
        start_d  = 1'b1;
        state_d  = WAIT_FIN;
      end
      WAIT_FIN: begin
        if (finish) begin
          state_d  = DRAIN;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(DRAIN_CYCLES - 1);
        end
      end
      DRAIN: begin
        if (tmr_zero) begin
          len_d    = '0;
          indata_d = '0;
          total_d  = '0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE) || (state_d == FILL);
  end

  always_ff @(posedge in_clk) begin
    if (reset) begin
      state_q  <= IDLE;
      k_q      <= '0;
      total_q  <= '0;
      buf_q    <= '0;
      indata_q <= '0;
      len_q    <= '0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      pend_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      total_q  <= total_d;
      buf_q    <= buf_d;
      indata_q <= indata_d;
      len_q    <= len_d;
      start_q  <= start_d;
      done_q   <= done_d;
      pend_q   <= pend_d;
      ready_q  <= ready_d;
    end
  end

  assign byte_ready = ready_q;
  assign indata     = indata_q;
  assign len        = len_q;
  assign start      = start_q;
  assign done       = done_q;

endmodule
